// File: rtl/mem_ctrl_pkg.sv
// =============================================================================
// mem_ctrl_pkg : shared types, defaults and width helpers for mem_ctrl.
// Rev 1.0
// =============================================================================
`default_nettype none

package mem_ctrl_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int RSP_DEPTH_DEF = 2;

    // Width of a counter that must hold 0..depth inclusive
    function automatic int cnt_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/resp_fifo.sv
// =============================================================================
// resp_fifo : synchronous WORD x DEPTH FIFO holding read responses in order.
// Rev 1.0
// =============================================================================
`default_nettype none

module resp_fifo
    import mem_ctrl_pkg::*;
#(
    parameter int WORD  = 4,
    parameter int DEPTH = RSP_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [WORD-1:0] push_data,
    input  logic            pop,
    output logic [WORD-1:0] head,
    output logic            empty,
    output logic            full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = cnt_width(DEPTH);

    logic [WORD-1:0] r_mem [DEPTH];
    logic [PW-1:0]   r_rd;
    logic [PW-1:0]   r_wr;
    logic [CW-1:0]   r_cnt;
    logic            w_do_push;
    logic            w_do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty     = (r_cnt == '0);
    assign full      = (r_cnt == CW'(DEPTH));
    assign head      = r_mem[r_rd];
    // A pop from empty is ignored, so a push into an empty FIFO still lands
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= push_data;
                r_wr        <= ptr_inc(r_wr);
            end
            if (w_do_pop) begin
                r_rd <= ptr_inc(r_rd);
            end
            if (w_do_push && !w_do_pop) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_ctrl.sv
// =============================================================================
// mem_ctrl : valid/ready request front-end serialising reads/writes onto a
// single-port mem, returning read data in order. Optional MEM_CTRL_CLR_EN
// enables a power-up sweep writing zero to every address.
// Rev 1.0
// =============================================================================
`default_nettype none

module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR      = 4,
    parameter int WORD      = 4,
    parameter int RD_LAT    = 1,
    parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wr,
    input  logic [ADDR-1:0] req_addr,
    input  logic [WORD-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [WORD-1:0] rsp_data,
    output logic [ADDR-1:0] mem_addr,
    output logic [WORD-1:0] mem_data_in,
    output logic            mem_wr,
    input  logic [WORD-1:0] mem_data_out,
    output logic            busy
);

    localparam int            CW      = cnt_width(RSP_DEPTH);
    localparam logic [CW-1:0] C_DEPTH = CW'(RSP_DEPTH);
`ifdef MEM_CTRL_CLR_EN
    localparam state_t          C_RST_STATE = CLEAR;
    localparam logic [ADDR:0]   C_CLR_END   = {1'b1, {ADDR{1'b0}}};
`else
    localparam state_t          C_RST_STATE = RUN;
`endif

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_ready;
    logic            r_busy, w_busy_nxt;
    logic [ADDR-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [WORD-1:0] r_mem_din, w_mem_din_nxt;
    logic            r_mem_wr, w_mem_wr_nxt;
    logic [RD_LAT:0] r_rd_pipe;
    logic            w_acc, w_acc_rd, w_pop, w_push;
    logic            w_fifo_empty, w_fifo_full;
`ifdef MEM_CTRL_CLR_EN
    logic [ADDR:0]   r_clr, w_clr_nxt;
`endif

    assign w_acc    = r_ready && req_valid;
    assign w_acc_rd = w_acc && !req_wr;
    assign w_pop    = rsp_valid && rsp_ready;
    // Bit 0 tags the mem issue cycle; bit RD_LAT lines up with mem_data_out
    assign w_push   = r_rd_pipe[RD_LAT] && (!w_fifo_full || w_pop);

    always_comb begin
        w_state_nxt    = r_state;
        w_busy_nxt     = 1'b0;
        w_mem_wr_nxt   = 1'b0;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_din_nxt  = r_mem_din;
        w_cnt_nxt      = r_cnt;
`ifdef MEM_CTRL_CLR_EN
        w_clr_nxt      = r_clr;
        if (r_state == CLEAR) begin
            // One extra CLEAR cycle after the last address keeps busy high
            // while the final zero write is on the port
            if (r_clr == C_CLR_END) begin
                w_state_nxt = RUN;
            end else begin
                w_busy_nxt     = 1'b1;
                w_mem_wr_nxt   = 1'b1;
                w_mem_addr_nxt = r_clr[ADDR-1:0];
                w_mem_din_nxt  = '0;
                w_clr_nxt      = r_clr + (ADDR+1)'(1);
            end
        end else
`endif
        if (w_acc) begin
            w_mem_wr_nxt   = req_wr;
            w_mem_addr_nxt = req_addr;
            if (req_wr) begin
                w_mem_din_nxt = req_wdata;
            end
        end
        if (w_acc_rd && !w_pop) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end else if (w_pop && !w_acc_rd) begin
            w_cnt_nxt = r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= C_RST_STATE;
            r_cnt      <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_wr   <= 1'b0;
            r_rd_pipe  <= '0;
`ifdef MEM_CTRL_CLR_EN
            r_clr      <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ready    <= (w_state_nxt == RUN) && (w_cnt_nxt < C_DEPTH);
            r_busy     <= w_busy_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_din  <= w_mem_din_nxt;
            r_mem_wr   <= w_mem_wr_nxt;
            r_rd_pipe  <= {r_rd_pipe[RD_LAT-1:0], w_acc_rd};
`ifdef MEM_CTRL_CLR_EN
            r_clr      <= w_clr_nxt;
`endif
        end
    end

    resp_fifo #(
        .WORD  (WORD),
        .DEPTH (RSP_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (mem_data_out),
        .pop       (w_pop),
        .head      (rsp_data),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full)
    );

    assign rsp_valid   = !w_fifo_empty;
    assign req_ready   = r_ready;
    assign busy        = r_busy;
    assign mem_addr    = r_mem_addr;
    assign mem_data_in = r_mem_din;
    assign mem_wr      = r_mem_wr;

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// =============================================================================
// tb_mem_ctrl : directed self-checking bench for mem_ctrl with a behavioural
// 16x4 single-port memory (one-cycle registered read) attached.
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_mem_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_wr = 1'b0;
    logic [3:0] req_addr = '0;
    logic [3:0] req_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [3:0] rsp_data;
    logic [3:0] mem_addr;
    logic [3:0] mem_data_in;
    logic       mem_wr;
    logic [3:0] mem_data_out = '0;
    logic       busy;

    logic [3:0] mem_arr [16];
    logic [3:0] shadow  [16];
    logic [3:0] expq [$];
    int         vectors = 0;
    int         miscompares = 0;

`ifdef MEM_CTRL_CLR_EN
    localparam int EXP_BUSY = 16;
`else
    localparam int EXP_BUSY = 0;
`endif

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_wr       (mem_wr),
        .mem_data_out (mem_data_out),
        .busy         (busy)
    );

    // Single-port memory: write-on-wr, registered read of the same address
    always @(posedge clk) begin
        if (mem_wr) mem_arr[mem_addr] <= mem_data_in;
        mem_data_out <= mem_arr[mem_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("ready_wait", 32'(req_ready), 32'd1);
    endtask

    task automatic release_check();
        int n = 0;
        rst_n = 1'b1;
        step();
        while (busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
        chk("busy_cycles", 32'(n), 32'(EXP_BUSY));
        chk("ready_after_rel", 32'(req_ready), 32'd1);
`ifdef MEM_CTRL_CLR_EN
        for (int i = 0; i < 16; i++) shadow[i] = 4'h0;
`endif
    endtask

    task automatic do_write(input logic [3:0] a, input logic [3:0] d);
        wait_ready();
        req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d;
        step();
        req_valid = 1'b0; req_wr = 1'b0;
        shadow[a] = d;
    endtask

    task automatic read_check(input string tag, input logic [3:0] a, input logic [3:0] exp);
        wait_ready();
        req_valid = 1'b1; req_wr = 1'b0; req_addr = a;
        step();
        req_valid = 1'b0;
        step();
        step();
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_data"}, 32'(rsp_data), 32'(exp));
        step();
    endtask

    initial begin
        int sent;
        int got;
        for (int i = 0; i < 16; i++) begin
            mem_arr[i] = 4'(15 - i);
            shadow[i]  = 4'(15 - i);
        end

        // Reset values
        step();
        step();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_din", 32'(mem_data_in), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        release_check();

`ifdef MEM_CTRL_CLR_EN
        for (int i = 0; i < 16; i++) read_check("clr_read", 4'(i), 4'h0);
`endif

        // Back-to-back writes, then two reads with rsp_ready high
        rsp_ready = 1'b1;
        wait_ready();
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'd2; req_wdata = 4'd7;
        step();
        chk("t1_wr0_mem_wr", 32'(mem_wr), 32'd1);
        chk("t1_wr0_addr", 32'(mem_addr), 32'd2);
        chk("t1_wr0_din", 32'(mem_data_in), 32'd7);
        req_addr = 4'd3; req_wdata = 4'd5;
        step();
        chk("t1_wr1_addr", 32'(mem_addr), 32'd3);
        chk("t1_wr1_din", 32'(mem_data_in), 32'd5);
        shadow[2] = 4'd7; shadow[3] = 4'd5;
        chk("t1_rd0_ready", 32'(req_ready), 32'd1);
        req_wr = 1'b0; req_addr = 4'd2;
        step();
        chk("t1_rd0_mem_wr", 32'(mem_wr), 32'd0);
        chk("t1_rd0_addr", 32'(mem_addr), 32'd2);
        chk("t1_rd1_ready", 32'(req_ready), 32'd1);
        req_addr = 4'd3;
        step();
        req_valid = 1'b0;
        chk("t1_c2_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t1_c2_stall", 32'(req_ready), 32'd0);
        step();
        chk("t1_c3_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_c3_rsp_data", 32'(rsp_data), 32'd7);
        chk("t1_c3_stall", 32'(req_ready), 32'd0);
        step();
        chk("t1_c4_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_c4_rsp_data", 32'(rsp_data), 32'd5);
        chk("t1_c4_ready", 32'(req_ready), 32'd1);
        step();
        chk("t1_c5_rsp_valid", 32'(rsp_valid), 32'd0);

        // Write immediately followed by a read of the same address
        wait_ready();
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'd4; req_wdata = 4'd9;
        step();
        shadow[4] = 4'd9;
        req_wr = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        step();
        chk("t2_raw_valid", 32'(rsp_valid), 32'd1);
        chk("t2_raw_data", 32'(rsp_data), 32'd9);
        step();

        // Credit stall with rsp_ready low, then drain
        rsp_ready = 1'b0;
        wait_ready();
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd2;
        step();
        chk("t3_rd1_ready", 32'(req_ready), 32'd1);
        req_addr = 4'd3;
        step();
        chk("t3_rd2_stall", 32'(req_ready), 32'd0);
        req_addr = 4'd4;
        step();
        chk("t3_y3_stall", 32'(req_ready), 32'd0);
        chk("t3_y3_valid", 32'(rsp_valid), 32'd1);
        chk("t3_y3_data", 32'(rsp_data), 32'd7);
        step();
        chk("t3_y4_hold_data", 32'(rsp_data), 32'd7);
        chk("t3_y4_stall", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        step();
        chk("t3_y5_ready", 32'(req_ready), 32'd1);
        chk("t3_y5_data", 32'(rsp_data), 32'd5);
        step();
        req_valid = 1'b0;
        chk("t3_y6_valid", 32'(rsp_valid), 32'd0);
        step();
        chk("t3_y7_valid", 32'(rsp_valid), 32'd0);
        step();
        chk("t3_y8_valid", 32'(rsp_valid), 32'd1);
        chk("t3_y8_data", 32'(rsp_data), 32'd9);
        step();
        chk("t3_y9_valid", 32'(rsp_valid), 32'd0);

        // Streaming reads of addresses 0..3 with rsp_ready high
        do_write(4'd0, 4'hA);
        do_write(4'd1, 4'hB);
        rsp_ready = 1'b1;
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            req_valid = (sent < 4);
            req_wr    = 1'b0;
            req_addr  = 4'(sent);
            if (req_valid && req_ready) begin
                expq.push_back(shadow[sent]);
                sent++;
            end
            if (rsp_valid) begin
                if (expq.size() > 0) chk("t4_stream_data", 32'(rsp_data), 32'(expq.pop_front()));
                else chk("t4_unexpected", 32'(rsp_valid), 32'd0);
                got++;
            end
            step();
        end
        req_valid = 1'b0;
        chk("t4_count", 32'(got), 32'd4);
        step();
        step();
        step();
        chk("t4_no_dup", 32'(rsp_valid), 32'd0);

        // Reset while a read is in flight
        wait_ready();
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd2;
        step();
        req_valid = 1'b0;
        rst_n = 1'b0;
        step();
        chk("t5_rst_valid", 32'(rsp_valid), 32'd0);
        chk("t5_rst_ready", 32'(req_ready), 32'd0);
        chk("t5_rst_mem_wr", 32'(mem_wr), 32'd0);
        step();
        chk("t5_rst_valid2", 32'(rsp_valid), 32'd0);
        release_check();
        do_write(4'd5, 4'd3);
        read_check("t5_after", 4'd5, 4'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_ctrl.md
# mem_ctrl

Request front-end for the single-port `mem` block (`ADDR`/`WORD` parameterised, `clk`, `addr`, `data_in`, `wr`, `data_out`). It sits directly upstream of `mem`:
- accepts read/write requests over a valid/ready handshake;
- serialises them onto the memory port, one per cycle;
- returns read data in order through a backpressurable response channel.

Optional power-up clear sweep zeroes the memory before traffic is accepted.

## Interface
Parameters:
- `ADDR`, 4, address width; must match the attached `mem`
- `WORD`, 4, data width; must match the attached `mem`
- `RD_LAT`, 1, cycles from `mem_addr` presented (`mem_wr`=0) to `mem_data_out` valid
- `RSP_DEPTH`, 2, response buffer entries = max reads in flight plus buffered

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted when high with `req_valid`
- `req_wr`  in  1  1 = write, 0 = read
- `req_addr`  in  ADDR  request address
- `req_wdata`  in  WORD  write data (ignored for reads)
- `rsp_valid`  out  1  read data available
- `rsp_ready`  in  1  consumer takes `rsp_data` when high with `rsp_valid`
- `rsp_data`  out  WORD  read data, request order
- `mem_addr`  out  ADDR  to `mem.addr`
- `mem_data_in`  out  WORD  to `mem.data_in`
- `mem_wr`  out  1  to `mem.wr`
- `mem_data_out`  in  WORD  from `mem.data_out`
- `busy`  out  1  clear sweep in progress

## Operation
Reset is sampled at a `clk` edge with `rst_n`=0. It clears all state and drops any in-flight reads. Reset values:
- `req_ready`=0, `rsp_valid`=0, `rsp_data`=0
- `mem_addr`=0, `mem_data_in`=0, `mem_wr`=0
- `busy`=0
- state = CLEAR when `MEM_CTRL_CLR_EN` is defined, else RUN

Credit count `cnt` (width clog2(RSP_DEPTH+1)):
- +1 per accepted read
- −1 per response pop
- unchanged on the same cycle as both
- writes never touch `cnt`

Request acceptance:
- `req_ready` = (state==RUN) && (`cnt` < RSP_DEPTH), from registered state only; it never depends on `req_valid` or `req_wr`.
- When `cnt`==RSP_DEPTH, writes are also stalled. This is a deliberate simplification.
- Accepted write: next cycle drive `mem_wr`=1, `mem_addr`=`req_addr`, `mem_data_in`=`req_wdata`. No response is generated.
- Accepted read: next cycle drive `mem_wr`=0, `mem_addr`=`req_addr`. A RD_LAT-deep valid shift register tags the slot; `mem_data_out` is pushed into the response FIFO at the end of cycle issue+RD_LAT.
- Idle cycles (no accept): `mem_wr`=0; `mem_addr` and `mem_data_in` hold their last values.
- Operations reach `mem` strictly in acceptance order. A read accepted after a write to the same address returns the new data; no forwarding is needed.

Response FIFO:
- Credits guarantee it never overflows.
- Pop on `rsp_valid && rsp_ready`.
- Simultaneous push and pop is legal, including from empty (push lands, pop stays on the old head) and full.

## Timing
- Request handshake in cycle 0 → memory port driven in cycle 1.
- Read data on `mem_data_out` in cycle 1+RD_LAT → `rsp_valid` high from cycle 2+RD_LAT (cycle 3 at defaults).
- Sustained throughput is one request per cycle while credits remain. At RSP_DEPTH=2, RD_LAT=1, with `rsp_ready` tied high, reads sustain 2 per 4 cycles.
- `rsp_data` is stable while `rsp_valid`=1 and `rsp_ready`=0.
- When `rst_n` is asserted mid-operation, all outputs take their reset values on the next edge and pending responses are lost.

## Configuration
- `MEM_CTRL_CLR_EN` defined:
  - after reset release, state CLEAR with `busy`=1 and `req_ready`=0;
  - sweep writes 0 to addresses 0..2^ADDR−1, one per cycle (`mem_wr`=1);
  - then RUN, `busy`=0;
  - first `req_ready`=1 occurs 2^ADDR+1 cycles after the first cycle with `rst_n`=1.
- `MEM_CTRL_CLR_EN` undefined: no CLEAR state and no sweep counter; `busy` is tied 0; RUN directly after reset.

## Structure
- Package `mem_ctrl_pkg`: state enum {CLEAR, RUN}, default `RSP_DEPTH`, credit-width function.
- Sub-module `resp_fifo`: synchronous FIFO (`WORD` × `RSP_DEPTH`, push/pop/empty/full, `clk`/`rst_n`). The top level holds the FSM, credit counter, read-latency shift register and memory-port registers.

## Test plan
Defaults; each scenario attached to a real `mem` #(4,4).
- Write addr 2 = 7 and addr 3 = 5 back-to-back, then read 2 and read 3 with `rsp_ready`=1 → responses 7 then 5, first `rsp_valid` 3 cycles after the read handshake.
- Write addr 4 = 9 immediately followed by read addr 4 → `rsp_data`=9.
- `rsp_ready`=0, issue 3 reads → first two accepted, `req_ready`=0 on the third. Raise `rsp_ready` → pops in order, third accepted on the cycle after `cnt` drops below 2.
- `rsp_ready`=1, streaming reads of addresses 0..3 → no data lost and no duplicates; push and pop coincide without corruption.
- Issue a read, then pull `rst_n` low before `rsp_valid` → `rsp_valid` stays 0 and `req_ready`/`mem_wr` are 0 during reset; after release, normal traffic works.
- `MEM_CTRL_CLR_EN`: `busy`=1 for 16 cycles after reset, then reads of addresses 0..15 all return 0.
